// File: rtl/n_bit_serial_adder.sv
// Digit-serial add/sub: one DIGIT-wide slice plus a registered carry, LSB digit first. Result after NDIG cycles.
// Valid/ready on both sides; the result is held while out_ready=0. SERIAL_ADDER_SAT_EN enables signed saturation.
module n_bit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] answer,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("n_bit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_answer;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_slice;
  logic [DIGIT-1:0] w_sum;
  logic             w_c;
  logic             w_ovf;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res_final;

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands shift right each cycle so the active digit is always the low slice.
  assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_sum   = w_slice[DIGIT-1:0];
  assign w_c     = w_slice[DIGIT];
  // Carry into the top bit is recovered from the top bit's inputs and sum.
  assign w_ovf   = (r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1]) ^ w_c;
  assign w_acc_nxt = WIDTH'({w_sum, r_acc} >> DIGIT);

`ifdef SERIAL_ADDER_SAT_EN
  always_comb begin
    w_res_final = w_acc_nxt;
    if (w_ovf) begin
      // A wrapped negative-looking result means the true value overflowed upward.
      w_res_final = w_sum[DIGIT-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign w_res_final = w_acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_answer <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a     <= input1;
      r_b     <= input2 ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_answer <= w_res_final;
        r_cout   <= w_c;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign answer    = r_answer;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_n_bit_serial_adder.sv
// Scoreboarded bench for n_bit_serial_adder: directed corner cases plus randomized ops with random backpressure.
module tb_n_bit_serial_adder;
  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] ans;
    logic             cout;
    logic             ovf;
    int               acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] answer;
  logic             carry_out;
  logic             overflow;

  logic ord_force = 1'b0;
  logic rnd_bp    = 1'b0;
  logic rnd_rdy   = 1'b1;
  assign out_ready = rnd_bp ? rnd_rdy : ord_force;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic prev_ov = 1'b0;
  exp_t exp_q[$];
  int   rise_q[$];

  n_bit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .answer(answer), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t m;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    if (!s) begin
      full   = {1'b0, a} + {1'b0, b};
      r      = full[WIDTH-1:0];
      m.cout = full[WIDTH];
      m.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r      = a - b;
      m.cout = (a >= b);
      m.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
`ifdef SERIAL_ADDER_SAT_EN
    if (m.ovf) r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    m.ans = r;
    m.acc = 0;
    return m;
  endfunction

  // Caller is positioned just after a rising edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    bit   ok = 0;
    in_valid = 1'b1;
    input1   = a;
    input2   = b;
    sub      = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(a, b, s);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(answer), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q[0];
          if (!prev_ov) begin
            rise_q.push_back(cyc);
            chk("latency", 64'(cyc - e.acc), 64'(NDIG));
          end
          chk("answer", 64'(answer), 64'(e.ans));
          chk("carry_out", 64'(carry_out), 64'(e.cout));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    input1   = '0;
    input2   = '0;
    sub      = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_answer", 64'(answer), 64'd0);
    chk("rst_flags", 64'({carry_out, overflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    ord_force = 1'b1;
    send(32'd120, 32'd340, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 1'b0);
    send(32'd100, 32'd340, 1'b1);
    send(32'd340, 32'd100, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_drain();

    // Backpressure: result held, new operands ignored.
    ord_force = 1'b0;
    send(32'd1000, 32'd2000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 1);
      input1   = 32'd77;
      input2   = 32'd88;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    ord_force = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(32'd1, 32'd2, 1'b0);
    wait_drain();

    // Reset while in RUN discards the operation.
    send(32'd9, 32'd9, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_answer", 64'(answer), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd5, 32'd7, 1'b0);
    wait_drain();

    // Back-to-back throughput.
    rise_q.delete();
    send(32'd1, 32'd1, 1'b0);
    send(32'd2, 32'd2, 1'b0);
    send(32'd3, 32'd3, 1'b0);
    wait_drain();
    chk("b2b_count", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() == 3) begin
      chk("b2b_gap0", 64'(rise_q[1] - rise_q[0]), 64'(NDIG + 2));
      chk("b2b_gap1", 64'(rise_q[2] - rise_q[1]), 64'(NDIG + 2));
    end

    // Randomized ops under random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        default: ;
      endcase
      send(a, b, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rnd_bp = 1'b0;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/n_bit_serial_adder.md
Name: n_bit_serial_adder

Overview:
- Parametrised multi-cycle successor to the combinational 32-bit N_bit_adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, LSB digit first, using a single DIGIT-wide adder slice plus a registered carry.
- Uses valid/ready handshakes on both the operand side and the result side.
- Sits between operand producers and result consumers in the datapath when area matters more than latency.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 8, bits processed per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails.
- NDIG, WIDTH/DIGIT, derived localparam: number of digit cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- input1  input  WIDTH  operand A, unsigned or two's complement.
- input2  input  WIDTH  operand B.
- sub  input  1  0 gives A+B; 1 gives A-B. Sampled with the operands.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- answer  output  WIDTH  sum or difference.
- carry_out  output  1  add: carry out of the MSB. Sub: no-borrow flag (1 when A>=B unsigned).
- overflow  output  1  signed overflow of the operation.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - answer=0, carry_out=0, overflow=0.
  - Digit counter=0 and internal carry=0.
  - Any operation in flight is discarded.
- FSM has three states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On in_valid && in_ready, latch A, B^{WIDTH{sub}} and sub.
  - Set carry=sub and counter=0, then go to RUN.
- RUN:
  - Each cycle computes {c, s} = A[d] + B'[d] + carry for the current digit d.
  - s is shifted into the result register from the MSB side; carry takes c; counter increments.
  - On the last digit (counter==NDIG-1):
    - carry_out = c.
    - overflow = carry into the MSB xor carry out of the MSB, computed from the top bit of the slice.
    - Go to DONE.
- DONE:
  - answer, carry_out and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; in_ready=1 on the following cycle.
  - No new operands are accepted in DONE.
- Latency: operands accepted at edge T give out_valid=1 after edge T+NDIG. Throughput is one operation per NDIG+2 cycles at best.
- in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- After out_ready, answer, carry_out and overflow keep their last values until the next result. They are meaningful only while out_valid=1.
- DIGIT==WIDTH is legal: RUN lasts exactly 1 cycle.
- Arithmetic is modulo 2^WIDTH. There is no sign extension and no extra result bits.

Optional Feature:
- Macro: SERIAL_ADDER_SAT_EN.
- Defined: on overflow=1, answer saturates to the signed limit.
  - Positive overflow gives {0,{WIDTH-1{1}}}.
  - Negative overflow gives {1,{WIDTH-1{0}}}.
  - The saturated value is applied on the transition into DONE. overflow and carry_out are still reported.
- Undefined: answer wraps modulo 2^WIDTH and there is no saturation logic.

Test Plan (WIDTH=32, DIGIT=8, NDIG=4):
- 120+340, out_ready=1 -> answer=460, carry_out=0, overflow=0; out_valid rises exactly 4 cycles after the accept edge.
- 0xFFFFFFFF+1 -> answer=0, carry_out=1, overflow=0. Then 0x7FFFFFFF+1 -> answer=0x80000000 (with SAT_EN: 0x7FFFFFFF), overflow=1, carry_out=0.
- sub: 100-340 -> answer=0xFFFFFF10, carry_out=0, overflow=0. sub: 340-100 -> answer=240, carry_out=1.
- Backpressure: out_ready held 0 for 5 cycles after result; in_valid pulsed with new operands -> answer/flags stable, in_ready=0, pulse ignored. After out_ready=1, in_ready=1 the next cycle and the next op (1+2) returns 3.
- rst_n pulsed low during RUN cycle 2 -> immediately out_valid=0, in_ready=1, answer=0. The next op (5+7) returns 12 with normal 4-cycle latency.
- Back-to-back ops with in_valid and out_ready held high: 1+1, 2+2, 3+3 -> answers 2, 4, 6 in order, with out_valid pulses 6 cycles apart.
